// File: rtl/noc_pkg.sv
// noc_pkg: packet field positions, direction codes and the stored FIFO entry type
package noc_pkg;
    localparam int PKT_W     = 64;
    localparam int PKT_Y_MSB = 63;
    localparam int PKT_Y_LSB = 48;
    localparam int PKT_X_MSB = 47;
    localparam int PKT_X_LSB = 32;
    localparam int PKT_D_MSB = 31;
    localparam int PKT_D_LSB = 0;

    localparam logic [2:0] DIR_LOCAL = 3'd0;
    localparam logic [2:0] DIR_RIGHT = 3'd1;
    localparam logic [2:0] DIR_LEFT  = 3'd2;
    localparam logic [2:0] DIR_UP    = 3'd3;
    localparam logic [2:0] DIR_DOWN  = 3'd4;

    typedef struct packed {
        logic [2:0]       dir;
        logic [PKT_W-1:0] pkt;
    } entry_t;
endpackage

// File: rtl/noc_xy_route_calc.sv
// noc_xy_route_calc: XY dimension-order output direction for a packet at node (x, y)
module noc_xy_route_calc
    import noc_pkg::*;
(
    input  logic [15:0]      x,
    input  logic [15:0]      y,
    input  logic [PKT_W-1:0] pkt,
    output logic [2:0]       dir
);
    logic [15:0] dst_x;
    logic [15:0] dst_y;
    logic        unused_data;

    assign dst_x       = pkt[PKT_X_MSB:PKT_X_LSB];
    assign dst_y       = pkt[PKT_Y_MSB:PKT_Y_LSB];
    assign unused_data = ^pkt[PKT_D_MSB:PKT_D_LSB];

    // Resolve X first, then Y; unsigned compares
    always_comb begin
        dir = (x < dst_x) ? DIR_RIGHT :
              (x > dst_x) ? DIR_LEFT  :
              (y > dst_y) ? DIR_UP    :
              (y < dst_y) ? DIR_DOWN  : DIR_LOCAL;
    end
endmodule

// File: rtl/noc_input_buffer.sv
// noc_input_buffer: per-port input FIFO that tags each packet with its XY direction at write time.
// Optional NOC_INBUF_DROP_EN: in_ready stays high and pushes into a full FIFO are discarded and counted.
module noc_input_buffer
    import noc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      x,
    input  logic [15:0]      y,
    input  logic             in_valid,
    input  logic [PKT_W-1:0] in_pkt,
    output logic             in_ready,
    output logic             out_valid,
    output logic [PKT_W-1:0] out_pkt,
    output logic [2:0]       out_dir,
    input  logic             out_ready,
    output logic [PTR_W:0]   count
`ifdef NOC_INBUF_DROP_EN
    ,
    output logic [15:0]      drop_cnt
`endif
);
    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [2:0]       in_dir;
    logic             full;
    logic             push;
    logic             pop;

    noc_xy_route_calc u_route (
        .x   (x),
        .y   (y),
        .pkt (in_pkt),
        .dir (in_dir)
    );

    assign full      = count == (PTR_W+1)'(DEPTH);
    assign out_valid = count != '0;
    assign out_pkt   = mem[rd_ptr].pkt;
    assign out_dir   = mem[rd_ptr].dir;
    assign pop       = out_valid & out_ready;
    // With back-pressure in_ready already excludes full; in drop mode a full push only lands alongside a pop
    assign push      = in_valid & in_ready & (!full | pop);
`ifdef NOC_INBUF_DROP_EN
    assign in_ready  = !rst;
`else
    assign in_ready  = !rst & !full;
`endif

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

    // Entry storage: packet plus the direction computed as it arrives
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= '{dir: in_dir, pkt: in_pkt};
        end
    end

`ifdef NOC_INBUF_DROP_EN
    // Saturating count of packets discarded because the FIFO was full with no pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) drop_cnt <= '0;
        else if (in_valid & in_ready & full & !pop & (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_noc_input_buffer.sv
// tb_noc_input_buffer: directed table-driven and sequence checks for noc_input_buffer at node (1,1)
module tb_noc_input_buffer;
    import noc_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] x = 16'd1;
    logic [15:0] y = 16'd1;
    logic        in_valid = 1'b0;
    logic [63:0] in_pkt = '0;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] out_pkt;
    logic [2:0]  out_dir;
    logic        out_ready = 1'b0;
    logic [2:0]  count;
`ifdef NOC_INBUF_DROP_EN
    logic [15:0] drop_cnt;
`endif

    int checks = 0;
    int failures = 0;

    noc_input_buffer #(.DEPTH(4), .PTR_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .y         (y),
        .in_valid  (in_valid),
        .in_pkt    (in_pkt),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_pkt   (out_pkt),
        .out_dir   (out_dir),
        .out_ready (out_ready),
        .count     (count)
`ifdef NOC_INBUF_DROP_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [63:0] pkt;
        logic [2:0]  dir;
    } rvec_t;

    rvec_t       rv[5];
    logic [63:0] fill[4];
    logic [63:0] extra;

    initial begin
        rv[0] = '{64'h0001_0003_DEADBEEF, DIR_RIGHT};
        rv[1] = '{64'h0001_0000_11111111, DIR_LEFT};
        rv[2] = '{64'h0000_0001_22222222, DIR_UP};
        rv[3] = '{64'h0002_0001_33333333, DIR_DOWN};
        rv[4] = '{64'h0001_0001_44444444, DIR_LOCAL};
        for (int i = 0; i < 4; i++) fill[i] = {16'd1, 16'd3, 32'hA000_0000 + i};
        extra = 64'h0001_0000_FFFF0005;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_pkt", out_pkt, 64'd0);
        chk("rst_out_dir", 64'(out_dir), 64'd0);
        rst = 1'b0;
        #1;
        chk("rel_in_ready", 64'(in_ready), 64'd1);

        // Routing table: write, see it next cycle with its direction, pop
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_pkt = rv[i].pkt;
            chk($sformatf("route%0d_pre_valid", i), 64'(out_valid), 64'd0);
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("route%0d_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("route%0d_pkt", i), out_pkt, rv[i].pkt);
            chk($sformatf("route%0d_dir", i), 64'(out_dir), 64'(rv[i].dir));
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            chk($sformatf("route%0d_count", i), 64'(count), 64'd0);
        end

        // Fill with no pops, then hold a 5th push
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_pkt = fill[i];
        end
        @(negedge clk);
        in_pkt = extra;
`ifdef NOC_INBUF_DROP_EN
        chk("full_in_ready", 64'(in_ready), 64'd1);
        repeat (3) @(negedge clk);
        chk("drop_cnt", 64'(drop_cnt), 64'd3);
`else
        chk("full_in_ready", 64'(in_ready), 64'd0);
        repeat (2) @(negedge clk);
`endif
        chk("full_count", 64'(count), 64'd4);
        chk("full_head_stable", out_pkt, fill[0]);
        chk("full_head_dir", 64'(out_dir), 64'(DIR_RIGHT));
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d_pkt", i), out_pkt, fill[i]);
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk("drain_count", 64'(count), 64'd0);
        chk("drain_valid", 64'(out_valid), 64'd0);

        // Simultaneous push/pop at count 2
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_pkt = 64'h0001_0001_0000_0100 + 64'(k);
            @(negedge clk);
        end
        for (int k = 0; k < 10; k++) begin
            in_pkt = 64'h0001_0001_0000_0100 + 64'(k + 2);
            out_ready = 1'b1;
            chk($sformatf("pp%0d_count", k), 64'(count), 64'd2);
            chk($sformatf("pp%0d_pkt", k), out_pkt, 64'h0001_0001_0000_0100 + 64'(k));
            @(negedge clk);
        end
        in_valid = 1'b0;
        for (int k = 10; k < 12; k++) begin
            chk($sformatf("pp_tail%0d_pkt", k), out_pkt, 64'h0001_0001_0000_0100 + 64'(k));
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk("pp_empty", 64'(count), 64'd0);

        // Wrap-around: push i while popping i-1
        for (int i = 0; i < 10; i++) begin
            in_valid = (i < 9);
            in_pkt = 64'(i);
            out_ready = (i > 0);
            if (i > 0) begin
                chk($sformatf("wrap%0d_count", i), 64'(count), 64'd1);
                chk($sformatf("wrap%0d_pkt", i), out_pkt, 64'(i - 1));
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("wrap_empty", 64'(count), 64'd0);

        // Reset mid-operation discards contents
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_pkt = fill[i];
            @(negedge clk);
        end
        chk("mid_count_pre", 64'(count), 64'd2);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_count", 64'(count), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
        chk("mid_rst_pkt", out_pkt, 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("mid_rel_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("mid_no_emit", 64'(out_valid), 64'd0);
        end
        out_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
